router_fsm: RTL and testbench

Packet-sequencing controller for the 1x3 router. It watches the incoming packet stream (`pkt_valid`, 2-bit destination address) and the status of the three output FIFOs. It then drives the load and write strobes that move header, payload and parity bytes into the selected FIFO. It also raises `busy` so the source stalls while the datapath cannot accept a byte.

---
 rtl/router_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_router_fsm.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// -----------------------------------------------------------------------------
// router_fsm
//
// Packet-sequencing controller for the 1x3 router. It watches the incoming
// packet stream and the status flags of the three output FIFOs. It then
// produces the Moore strobes that steer header, payload and parity bytes into
// the selected FIFO, and it holds off the source with busy.
//
// Optional feature macro: ROUTER_FSM_PKT_CNT_EN
//   When defined, an 8-bit completed-packet counter and its pkt_count port
//   are added. The default build leaves both out.
//
// Parameters:
//   ADDR_W        destination address width (addresses 0..2 valid, 3 invalid)
//
// Ports:
//   clock         rising-edge clock
//   resetn        asynchronous active-low reset
//   pkt_valid     source is presenting packet bytes
//   data_in       destination address (low bits of the header byte)
//   fifo_full_*   full flags of FIFOs 0..2
//   fifo_empty_*  empty flags of FIFOs 0..2
//   soft_reset_*  per-FIFO soft reset from the read-timeout logic
//   parity_done   parity byte has been captured by the register block
//   low_pkt_valid pkt_valid fell while the FIFO was full
//   detect_add    address-decode phase
//   lfd_state     header write cycle
//   ld_state      payload load
//   laf_state     load-after-full
//   full_state    stalled on a full FIFO
//   write_enb_reg register block drives a byte toward the FIFO
//   rst_int_reg   clear the internal parity-error logic
//   busy          source must hold its current byte
//   pkt_count     completed-packet count (only with ROUTER_FSM_PKT_CNT_EN)
// -----------------------------------------------------------------------------
module router_fsm #(
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full_0,
    input  logic              fifo_full_1,
    input  logic              fifo_full_2,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy
`ifdef ROUTER_FSM_PKT_CNT_EN
    ,
    output logic [7:0]        pkt_count
`endif
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_sel;
    logic              addr_ok;
    logic              sel_full;
    logic              sel_empty;
    logic              sel_srst;

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= DECODE_ADDRESS;
        end else begin
            state <= next_state;
        end
    end

    // Destination address is captured while decoding so that later states
    // keep looking at the same FIFO even after data_in moves on to payload.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
        end else if (state == DECODE_ADDRESS && pkt_valid) begin
            addr_q <= data_in;
        end
    end

    // During decode the header is still on data_in and addr_q is stale, so
    // the flags are selected by the live address there. The invalid address
    // selects no FIFO at all, so its flags read as inactive.
    always_comb begin
        addr_sel  = (state == DECODE_ADDRESS) ? data_in : addr_q;
        addr_ok   = (data_in <= ADDR_W'(2));
        sel_full  = 1'b0;
        sel_empty = 1'b0;
        sel_srst  = 1'b0;
        case (addr_sel)
            ADDR_W'(0): begin
                sel_full  = fifo_full_0;
                sel_empty = fifo_empty_0;
                sel_srst  = soft_reset_0;
            end
            ADDR_W'(1): begin
                sel_full  = fifo_full_1;
                sel_empty = fifo_empty_1;
                sel_srst  = soft_reset_1;
            end
            ADDR_W'(2): begin
                sel_full  = fifo_full_2;
                sel_empty = fifo_empty_2;
                sel_srst  = soft_reset_2;
            end
            default: begin
                sel_full  = 1'b0;
                sel_empty = 1'b0;
                sel_srst  = 1'b0;
            end
        endcase
    end

    // Next-state logic. A soft reset of the selected FIFO discards the packet
    // in progress, so it overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && addr_ok) begin
                    next_state = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: begin
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (sel_full) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!sel_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    next_state = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                next_state = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                next_state = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) begin
                    next_state = LOAD_FIRST_DATA;
                end
            end
            default: begin
                next_state = DECODE_ADDRESS;
            end
        endcase
        if (sel_srst) begin
            next_state = DECODE_ADDRESS;
        end
    end

    // Moore output decode. The source may only present a new byte while we
    // are decoding a header or streaming payload; everything else stalls it.
    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        full_state    = (state == FIFO_FULL_STATE);
        laf_state     = (state == LOAD_AFTER_FULL);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        write_enb_reg = (state == LOAD_DATA) ||
                        (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
        busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    end

`ifdef ROUTER_FSM_PKT_CNT_EN
    // A packet counts as complete only when the parity check hands control
    // back to address decode; the counter wraps naturally at 256.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_count <= 8'd0;
        end else if (state == CHECK_PARITY_ERROR && next_state == DECODE_ADDRESS) begin
            pkt_count <= pkt_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_router_fsm.sv
// -----------------------------------------------------------------------------
// tb_router_fsm
//
// Directed testbench for router_fsm. The outputs are packed into one byte
// {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
// rst_int_reg, busy}; each FSM state has a unique pattern, so comparing that
// byte against a hand-written constant identifies the state as well.
// Counter checks are compiled in only with ROUTER_FSM_PKT_CNT_EN.
// -----------------------------------------------------------------------------
module tb_router_fsm;

    localparam logic [7:0] O_DA   = 8'b1000_0000;
    localparam logic [7:0] O_LFD  = 8'b0100_0001;
    localparam logic [7:0] O_LD   = 8'b0010_0100;
    localparam logic [7:0] O_LP   = 8'b0000_0101;
    localparam logic [7:0] O_FULL = 8'b0000_1001;
    localparam logic [7:0] O_LAF  = 8'b0001_0101;
    localparam logic [7:0] O_WTE  = 8'b0000_0001;
    localparam logic [7:0] O_CPE  = 8'b0000_0011;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full_0, fifo_full_1, fifo_full_2;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
`ifdef ROUTER_FSM_PKT_CNT_EN
    logic [7:0] pkt_count;
`endif

    int test_count = 0;
    int fail_count = 0;

    router_fsm #(.ADDR_W(2)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full_0   (fifo_full_0),
        .fifo_full_1   (fifo_full_1),
        .fifo_full_2   (fifo_full_2),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
`ifdef ROUTER_FSM_PKT_CNT_EN
        ,
        .pkt_count     (pkt_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic pv, input logic [1:0] addr);
        pkt_valid = pv;
        data_in   = addr;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expected);
        logic [7:0] observed;
        observed = {detect_add, lfd_state, ld_state, laf_state, full_state,
                    write_enb_reg, rst_int_reg, busy};
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: outputs observed %b expected %b", tag, observed, expected);
        end
    endtask

`ifdef ROUTER_FSM_PKT_CNT_EN
    task automatic checkCount(input string tag, input logic [7:0] expected);
        test_count++;
        assert (pkt_count === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: pkt_count observed %0d expected %0d", tag, pkt_count, expected);
        end
    endtask
`endif

    initial begin
        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_in       = 2'd0;
        fifo_full_0   = 1'b0;
        fifo_full_1   = 1'b0;
        fifo_full_2   = 1'b0;
        fifo_empty_0  = 1'b1;
        fifo_empty_1  = 1'b1;
        fifo_empty_2  = 1'b1;
        soft_reset_0  = 1'b0;
        soft_reset_1  = 1'b0;
        soft_reset_2  = 1'b0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;

        // Reset state
        #1;
        checkOutput("reset_hold", O_DA);
`ifdef ROUTER_FSM_PKT_CNT_EN
        checkCount("reset_count", 8'd0);
`endif
        tick();
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("idle_after_reset", O_DA);

        // Normal packet to FIFO 1 with 4 payload bytes
        applyStimulus(1'b1, 2'd1);
        tick(); checkOutput("norm_lfd", O_LFD);
        tick(); checkOutput("norm_ld1", O_LD);
        tick(); checkOutput("norm_ld2", O_LD);
        tick(); checkOutput("norm_ld3", O_LD);
        tick(); checkOutput("norm_ld4", O_LD);
        applyStimulus(1'b0, 2'd0);
        tick(); checkOutput("norm_lp", O_LP);
        tick(); checkOutput("norm_cpe", O_CPE);
        tick(); checkOutput("norm_da", O_DA);
`ifdef ROUTER_FSM_PKT_CNT_EN
        checkCount("norm_count", 8'd1);
`endif
        tick(); checkOutput("norm_idle", O_DA);

        // Wait for FIFO 2 to drain
        fifo_empty_2 = 1'b0;
        applyStimulus(1'b1, 2'd2);
        for (int i = 0; i < 5; i++) begin
            tick(); checkOutput($sformatf("wte_%0d", i), O_WTE);
        end
        fifo_empty_2 = 1'b1;
        tick(); checkOutput("wte_lfd", O_LFD);
        tick(); checkOutput("wte_ld", O_LD);
        applyStimulus(1'b0, 2'd0);
        tick(); checkOutput("wte_lp", O_LP);
        tick(); checkOutput("wte_cpe", O_CPE);
        tick(); checkOutput("wte_da", O_DA);

        // Full stall on FIFO 0, resume into LOAD_DATA, then end via low_pkt_valid
        applyStimulus(1'b1, 2'd0);
        tick(); checkOutput("full_lfd", O_LFD);
        tick(); checkOutput("full_ld", O_LD);
        fifo_full_0 = 1'b1;
        tick(); checkOutput("full_1", O_FULL);
        tick(); checkOutput("full_2", O_FULL);
        tick(); checkOutput("full_3", O_FULL);
        fifo_full_0 = 1'b0;
        tick(); checkOutput("laf_1", O_LAF);
        tick(); checkOutput("laf_to_ld", O_LD);
        fifo_full_0 = 1'b1;
        tick(); checkOutput("full_again", O_FULL);
        fifo_full_0 = 1'b0;
        tick(); checkOutput("laf_2", O_LAF);
        low_pkt_valid = 1'b1;
        pkt_valid     = 1'b0;
        tick(); checkOutput("laf_to_lp", O_LP);
        low_pkt_valid = 1'b0;
        tick(); checkOutput("full_cpe", O_CPE);
        tick(); checkOutput("full_da", O_DA);
`ifdef ROUTER_FSM_PKT_CNT_EN
        checkCount("count_3", 8'd3);
`endif

        // Full and pkt_valid fall together: full wins; parity_done ends it
        applyStimulus(1'b1, 2'd0);
        tick(); checkOutput("race_lfd", O_LFD);
        tick(); checkOutput("race_ld", O_LD);
        pkt_valid   = 1'b0;
        fifo_full_0 = 1'b1;
        tick(); checkOutput("race_full", O_FULL);
        fifo_full_0 = 1'b0;
        tick(); checkOutput("race_laf", O_LAF);
        parity_done = 1'b1;
        tick(); checkOutput("race_pd_da", O_DA);
        parity_done = 1'b0;

        // FIFO full during parity check routes back into the stall
        applyStimulus(1'b1, 2'd0);
        tick(); checkOutput("cpef_lfd", O_LFD);
        tick(); checkOutput("cpef_ld", O_LD);
        pkt_valid = 1'b0;
        tick(); checkOutput("cpef_lp", O_LP);
        fifo_full_0 = 1'b1;
        tick(); checkOutput("cpef_cpe", O_CPE);
        tick(); checkOutput("cpef_full", O_FULL);
        fifo_full_0 = 1'b0;
        tick(); checkOutput("cpef_laf", O_LAF);
        parity_done = 1'b1;
        tick(); checkOutput("cpef_da", O_DA);
        parity_done = 1'b0;
`ifdef ROUTER_FSM_PKT_CNT_EN
        checkCount("count_still_3", 8'd3);
`endif

        // Soft reset: other FIFO ignored, selected FIFO aborts the packet
        applyStimulus(1'b1, 2'd1);
        tick(); checkOutput("srst_lfd", O_LFD);
        tick(); checkOutput("srst_ld", O_LD);
        soft_reset_0 = 1'b1;
        tick(); checkOutput("srst_other", O_LD);
        soft_reset_0 = 1'b0;
        soft_reset_1 = 1'b1;
        tick(); checkOutput("srst_sel", O_DA);
        soft_reset_1 = 1'b0;
        pkt_valid    = 1'b0;

        // Invalid address 3 keeps the FSM decoding
        applyStimulus(1'b1, 2'd3);
        tick(); checkOutput("addr3_1", O_DA);
        tick(); checkOutput("addr3_2", O_DA);
        applyStimulus(1'b0, 2'd0);

        // Asynchronous reset mid-packet
        applyStimulus(1'b1, 2'd2);
        tick(); checkOutput("arst_lfd", O_LFD);
        tick(); checkOutput("arst_ld", O_LD);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("arst_async", O_DA);
`ifdef ROUTER_FSM_PKT_CNT_EN
        checkCount("arst_count", 8'd0);
`endif
        applyStimulus(1'b0, 2'd0);
        #1;
        resetn = 1'b1;
        tick(); checkOutput("arst_idle", O_DA);

`ifdef ROUTER_FSM_PKT_CNT_EN
        // Counter wrap after 256 packets
        for (int p = 0; p < 256; p++) begin
            applyStimulus(1'b1, 2'd0);
            tick();
            tick();
            applyStimulus(1'b0, 2'd0);
            tick();
            tick();
            tick();
            if (p == 0) checkCount("wrap_first", 8'd1);
        end
        checkOutput("wrap_state", O_DA);
        checkCount("wrap_count", 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
